// File: rtl/pmem_line_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pmem_line_responder
//
// Target end of the 256-bit line-granular pmem read/write/resp protocol.
// Holds 2**LINE_IDX_BITS lines of 256 bits and serves one request at a time.
// pmem_resp pulses for one cycle exactly LATENCY cycles after the request is
// first seen high.
//
// Parameters:
//   LINE_IDX_BITS : line-index width; array depth = 2**LINE_IDX_BITS lines
//   LATENCY       : cycles from accept to pmem_resp, legal range 1..255
//
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset (storage array is kept)
//   pmem_read    : line read request, held until pmem_resp
//   pmem_write   : line write request, held until pmem_resp (wins over read)
//   pmem_address : byte address; line index = [LINE_IDX_BITS+4:5]
//   pmem_wdata   : write line data
//   pmem_resp    : one-cycle completion pulse
//   pmem_rdata   : read line data, valid in the pmem_resp cycle of a read
//   proto_err    : sticky protocol-violation flag
//
// Build option:
//   PMEM_PROTO_CHECK_EN : when defined, proto_err monitors initiator
//                         behaviour; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module pmem_line_responder #(
  parameter int LINE_IDX_BITS = 7,
  parameter int LATENCY       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  output logic         proto_err
);

  localparam int DEPTH = 2 ** LINE_IDX_BITS;

  // Illegal latency must stop elaboration.
  if ((LATENCY < 1) || (LATENCY > 255)) begin : g_bad_latency
    $error("pmem_line_responder: LATENCY must be in 1..255");
  end

  localparam logic [7:0] LOAD_CNT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic [7:0]               cnt_r;
  logic                     op_wr_r;
  logic [LINE_IDX_BITS-1:0] idx_r;
  logic [255:0]             wdata_r;
  logic                     accept_s;
  logic                     commit_s;
  logic                     op_wr_s;
  logic [LINE_IDX_BITS-1:0] idx_s;
  logic [255:0]             wdata_s;
  logic [255:0]             mem_r [DEPTH];

  // Address bits outside the line index never affect the data path.
  logic unused_addr_s;
  assign unused_addr_s = ^{pmem_address[31:LINE_IDX_BITS+5], pmem_address[4:0]};

  // Next-state decode; commit_s marks the edge that enters RESP.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pmem_read || pmem_write) begin
          accept_s = 1'b1;
          if (LATENCY == 1) begin
            state_s  = ST_RESP;
            commit_s = 1'b1;
          end else begin
            state_s = ST_BUSY;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == 8'd1) begin
          state_s  = ST_RESP;
          commit_s = 1'b1;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Operation used at the commit edge: live inputs when committing straight
  // out of IDLE (LATENCY=1), otherwise the values latched at accept.
  always_comb begin
    op_wr_s = op_wr_r;
    idx_s   = idx_r;
    wdata_s = wdata_r;
    if (state_r == ST_IDLE) begin
      op_wr_s = pmem_write;
      idx_s   = pmem_address[LINE_IDX_BITS+4:5];
      wdata_s = pmem_wdata;
    end else begin
      op_wr_s = op_wr_r;
      idx_s   = idx_r;
      wdata_s = wdata_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latches, latency counter, response pulse and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= 8'd0;
      op_wr_r    <= 1'b0;
      idx_r      <= '0;
      wdata_r    <= 256'd0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= 256'd0;
    end else begin
      pmem_resp <= commit_s;
      if (accept_s) begin
        op_wr_r <= pmem_write;
        idx_r   <= pmem_address[LINE_IDX_BITS+4:5];
        wdata_r <= pmem_wdata;
        cnt_r   <= LOAD_CNT;
      end else if (state_r == ST_BUSY) begin
        cnt_r <= cnt_r - 8'd1;
      end
      if (commit_s && !op_wr_s) begin
        pmem_rdata <= mem_r[idx_s];
      end
    end
  end

  // Storage array; a write abandoned by reset is never committed.
  always_ff @(posedge clk) begin
    if (commit_s && op_wr_s && !rst) begin
      mem_r[idx_s] <= wdata_s;
    end
  end

`ifdef PMEM_PROTO_CHECK_EN
  logic [26:0] addr_hi_r;
  logic        viol_s;
  logic        in_xact_s;

  // Violation detect: both lines high, or the held request changing while
  // a transaction is in flight.
  always_comb begin
    in_xact_s = (state_r == ST_BUSY) || (state_r == ST_RESP);
    viol_s    = pmem_read && pmem_write;
    if (in_xact_s) begin
      if (op_wr_r ? !pmem_write : !pmem_read) begin
        viol_s = 1'b1;
      end else if (pmem_address[31:5] != addr_hi_r) begin
        viol_s = 1'b1;
      end else if (op_wr_r && (pmem_wdata != wdata_r)) begin
        viol_s = 1'b1;
      end else begin
        viol_s = viol_s;
      end
    end else begin
      viol_s = viol_s;
    end
  end

  // Latched full line address and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hi_r <= 27'd0;
      proto_err <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_hi_r <= pmem_address[31:5];
      end
      if (viol_s) begin
        proto_err <= 1'b1;
      end
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pmem_line_responder
//
// Three responders (LATENCY 4, 1, 255) driven one at a time. A line-level
// reference model (array of lines plus "last read value") supplies every
// expected value; timing expectations come straight from LATENCY.
// -----------------------------------------------------------------------------
module tb_pmem_line_responder;

`ifdef PMEM_PROTO_CHECK_EN
  localparam bit PROTO_EN = 1'b1;
`else
  localparam bit PROTO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd    [3];
  logic         wr    [3];
  logic [31:0]  addr  [3];
  logic [255:0] wdata [3];
  logic         resp  [3];
  logic [255:0] rdata [3];
  logic         perr  [3];

  int lat_of [3] = '{4, 1, 255};

  // reference model: per-device line contents and last read data
  logic [255:0] model   [3][128];
  bit           known   [3][128];
  logic [255:0] last_rd [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pmem_line_responder #(.LINE_IDX_BITS(7), .LATENCY(4)) u_dut0 (
    .clk(clk), .rst(rst), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wdata[0]), .pmem_resp(resp[0]),
    .pmem_rdata(rdata[0]), .proto_err(perr[0]));

  pmem_line_responder #(.LINE_IDX_BITS(7), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wdata[1]), .pmem_resp(resp[1]),
    .pmem_rdata(rdata[1]), .proto_err(perr[1]));

  pmem_line_responder #(.LINE_IDX_BITS(7), .LATENCY(255)) u_dut2 (
    .clk(clk), .rst(rst), .pmem_read(rd[2]), .pmem_write(wr[2]),
    .pmem_address(addr[2]), .pmem_wdata(wdata[2]), .pmem_resp(resp[2]),
    .pmem_rdata(rdata[2]), .proto_err(perr[2]));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reset for n cycles; outputs must come back cleared, storage untouched.
  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0;
    end
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      last_rd[k] = 256'd0;
      check("rst_resp", resp[k], 1'b0);
      check("rst_rdata", rdata[k], 256'd0);
      check("rst_perr", perr[k], 1'b0);
    end
  endtask

  // One transaction on device d. The request stays high through the RESP
  // cycle and is dropped only in the cycle after it, so a re-accept would
  // show up as a second pulse. chg_cyc>0 moves the address in that cycle.
  task automatic xact(input int d, input bit do_rd, input bit do_wr,
                      input logic [31:0] a, input logic [255:0] wd,
                      input int chg_cyc, input logic [31:0] chg_a);
    int cyc;
    bit seen;
    int idx;
    int extra;
    logic [255:0] got;
    idx = int'(a[11:5]);
    rd[d] = do_rd; wr[d] = do_wr; addr[d] = a; wdata[d] = wd;
    cyc = 0; seen = 1'b0;
    while (!seen && (cyc <= lat_of[d] + 4)) begin
      @(posedge clk); #1;
      cyc++;
      if (resp[d]) seen = 1'b1;
      else if (cyc == chg_cyc) addr[d] = chg_a;
    end
    check("resp_seen", 256'(seen), 256'd1);
    check("latency", 256'(cyc), 256'(lat_of[d]));
    got = rdata[d];
    if (do_wr) begin
      check("rdata_hold_on_write", got, last_rd[d]);
      model[d][idx] = wd;
      known[d][idx] = 1'b1;
    end else begin
      if (known[d][idx]) begin
        check("rdata", got, model[d][idx]);
        last_rd[d] = model[d][idx];
      end else begin
        last_rd[d] = got;
      end
    end
    @(posedge clk); #1;
    check("resp_width", resp[d], 1'b0);
    rd[d] = 1'b0; wr[d] = 1'b0;
    extra = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp[d]) extra++;
    end
    check("no_reaccept", 256'(extra), 256'd0);
    check("rdata_hold_idle", rdata[d], last_rd[d]);
  endtask

  initial begin
    logic [255:0] d_dead;
    logic [255:0] d_a5;
    int nresp;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 256'd0;
      last_rd[k] = 256'd0;
      for (int j = 0; j < 128; j++) known[k][j] = 1'b0;
    end
    d_dead = {8{32'hDEADBEEF}};
    d_a5   = {32{8'hA5}};

    do_reset(2);

    // write then read back, same line through a different byte offset
    xact(0, 1'b0, 1'b1, 32'h0000_0040, d_dead, 0, 32'd0);
    xact(0, 1'b1, 1'b0, 32'h0000_0040, 256'd0, 0, 32'd0);
    check("readback_dead", last_rd[0], d_dead);
    xact(0, 1'b1, 1'b0, 32'h0000_005F, 256'd0, 0, 32'd0);

    // aliasing: 0x1040 and 0x40 map to line 2
    xact(0, 1'b0, 1'b1, 32'h0000_1040, 256'd1, 0, 32'd0);
    xact(0, 1'b1, 1'b0, 32'h0000_0040, 256'd0, 0, 32'd0);
    check("alias_read", last_rd[0], 256'd1);

    // reset in BUSY abandons the write
    xact(0, 1'b0, 1'b1, 32'h0000_0080, 256'd0, 0, 32'd0);
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h0000_0080; wdata[0] = d_a5;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; wr[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) last_rd[k] = 256'd0;
    nresp = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp[0]) nresp++;
    end
    check("no_resp_after_rst", 256'(nresp), 256'd0);
    check("rdata_cleared", rdata[0], 256'd0);
    xact(0, 1'b1, 1'b0, 32'h0000_0080, 256'd0, 0, 32'd0);
    check("abandoned_write", last_rd[0], 256'd0);

    // latency extremes
    xact(1, 1'b0, 1'b1, 32'h0000_0020, d_dead, 0, 32'd0);
    xact(1, 1'b1, 1'b0, 32'h0000_0020, 256'd0, 0, 32'd0);
    xact(2, 1'b0, 1'b1, 32'h0000_0FE0, d_a5, 0, 32'd0);
    xact(2, 1'b1, 1'b0, 32'h0000_0FE0, 256'd0, 0, 32'd0);

    // randomized traffic on the short-latency devices
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 50; n++) begin
        bit w;
        int li;
        logic [31:0] a;
        w  = 1'($urandom_range(0, 1));
        li = int'($urandom_range(0, 7));
        a  = {$urandom} & 32'hFFFF_F01F;
        a[11:5] = 7'(li);
        if (!known[d][li]) w = 1'b1;
        xact(d, !w, w, a, rand256(), 0, 32'd0);
      end
    end

    // both lines high: handled as a write, flagged when checking is built in
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0100; wdata[0] = d_a5;
    @(posedge clk); #1;
    check("perr_both_next", perr[0], PROTO_EN);
    rd[0] = 1'b0; wr[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("perr_sticky", perr[0], PROTO_EN);
    do_reset(1);

    xact(0, 1'b1, 1'b1, 32'h0000_0100, d_dead, 0, 32'd0);
    check("perr_both_xact", perr[0], PROTO_EN);
    xact(0, 1'b1, 1'b0, 32'h0000_0100, 256'd0, 0, 32'd0);
    do_reset(1);

    // address moved mid-BUSY: data still from the latched line
    xact(0, 1'b0, 1'b1, 32'h0000_0060, 256'd7, 0, 32'd0);
    xact(0, 1'b1, 1'b0, 32'h0000_0040, 256'd0, 2, 32'h0000_0060);
    check("perr_addr_change", perr[0], PROTO_EN);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
